// File: rtl/maxnet_job_ctrl_if.sv
// maxnet_job_ctrl_if: host candidate stream, Maxnet bank/start/done and result port.
// The master side is the job controller; the slave side is the host plus Maxnet core.
interface maxnet_job_ctrl_if #(
    parameter int N_IN  = 4,
    parameter int WIDTH = 32
);
    localparam int AW = $clog2(N_IN);

    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             mx_wr_en;
    logic [AW-1:0]    mx_wr_addr;
    logic [WIDTH-1:0] mx_wr_data;
    logic             mx_start;
    logic             mx_done;
    logic [WIDTH-1:0] mx_maxnumber;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic             res_timeout;
    logic             busy;

    modport master (
        input  in_valid, in_data, mx_done, mx_maxnumber, res_ready,
        output in_ready, mx_wr_en, mx_wr_addr, mx_wr_data, mx_start,
               res_valid, res_data, res_timeout, busy
    );

    modport slave (
        output in_valid, in_data, mx_done, mx_maxnumber, res_ready,
        input  in_ready, mx_wr_en, mx_wr_addr, mx_wr_data, mx_start,
               res_valid, res_data, res_timeout, busy
    );
endinterface

// File: rtl/maxnet_job_ctrl.sv
// maxnet_job_ctrl: loads N_IN candidates into the Maxnet bank, pulses start, waits for
// done under a timeout guard and hands the captured maximum back over a valid/ready port.
module maxnet_job_ctrl #(
    parameter int N_IN         = 4,
    parameter int WIDTH        = 32,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 1023
) (
    input logic               clk,
    input logic               rst,
    maxnet_job_ctrl_if.master bus
);
    localparam int AW = $clog2(N_IN);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(START_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {LOAD, START, WAIT, RESP} state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [SW-1:0]    sc_q, sc_d;
    logic [TW-1:0]    tmo_q, tmo_d;
    logic             wr_en_q, wr_en_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic             start_q, start_d;
    logic             res_valid_q, res_valid_d;
    logic [WIDTH-1:0] res_data_q, res_data_d;
    logic             res_timeout_q, res_timeout_d;
    logic             busy_q, busy_d;
    logic             in_hs;

    assign bus.in_ready    = (state_q == LOAD);
    assign in_hs           = bus.in_valid & bus.in_ready;
    assign bus.mx_wr_en    = wr_en_q;
    assign bus.mx_wr_addr  = wr_addr_q;
    assign bus.mx_wr_data  = wr_data_q;
    assign bus.mx_start    = start_q;
    assign bus.res_valid   = res_valid_q;
    assign bus.res_data    = res_data_q;
    assign bus.res_timeout = res_timeout_q;
    assign bus.busy        = busy_q;

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        sc_d          = sc_q;
        tmo_d         = tmo_q;
        wr_en_d       = 1'b0;
        wr_addr_d     = wr_addr_q;
        wr_data_d     = wr_data_q;
        start_d       = 1'b0;
        res_valid_d   = res_valid_q;
        res_data_d    = res_data_q;
        res_timeout_d = res_timeout_q;
        busy_d        = busy_q;
        case (state_q)
            LOAD: if (in_hs) begin
                wr_en_d   = 1'b1;
                wr_addr_d = cnt_q[AW-1:0];
                wr_data_d = bus.in_data;
                busy_d    = 1'b1;
                cnt_d     = (cnt_q == CW'(N_IN - 1)) ? '0 : cnt_q + CW'(1);
                sc_d      = '0;
                state_d   = (cnt_q == CW'(N_IN - 1)) ? START : LOAD;
            end
            // START lasts START_CYCLES+1 cycles: the first only arms the registered strobe
            START: if (sc_q == SW'(START_CYCLES)) begin
                state_d = WAIT;
                tmo_d   = '0;
            end else begin
                start_d = 1'b1;
                sc_d    = sc_q + SW'(1);
            end
            WAIT: begin
                tmo_d = (tmo_q == TW'(TIMEOUT)) ? tmo_q : tmo_q + TW'(1);
                if (bus.mx_done || tmo_q == TW'(TIMEOUT - 1)) begin
                    state_d       = RESP;
                    res_valid_d   = 1'b1;
                    res_timeout_d = !bus.mx_done;
                    res_data_d    = bus.mx_done ? bus.mx_maxnumber : '0;
                end
            end
            RESP: if (bus.res_ready) begin
                state_d       = LOAD;
                res_valid_d   = 1'b0;
                res_timeout_d = 1'b0;
                busy_d        = 1'b0;
            end
            default: state_d = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= LOAD;
            cnt_q         <= '0;
            sc_q          <= '0;
            tmo_q         <= '0;
            wr_en_q       <= 1'b0;
            wr_addr_q     <= '0;
            wr_data_q     <= '0;
            start_q       <= 1'b0;
            res_valid_q   <= 1'b0;
            res_data_q    <= '0;
            res_timeout_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            sc_q          <= sc_d;
            tmo_q         <= tmo_d;
            wr_en_q       <= wr_en_d;
            wr_addr_q     <= wr_addr_d;
            wr_data_q     <= wr_data_d;
            start_q       <= start_d;
            res_valid_q   <= res_valid_d;
            res_data_q    <= res_data_d;
            res_timeout_q <= res_timeout_d;
            busy_q        <= busy_d;
        end
    end
endmodule

// File: tb/tb_maxnet_job_ctrl.sv
// tb_maxnet_job_ctrl: randomized jobs against a Maxnet responder model; expected writes
// and results are queued at stimulus time and popped by a negedge monitor.
module tb_maxnet_job_ctrl;
    localparam int N  = 4;
    localparam int W  = 32;
    localparam int AW = $clog2(N);
    localparam int SC = 2;
    localparam int TO = 24;

    typedef struct packed {logic [AW-1:0] a; logic [W-1:0] d;} wr_t;
    typedef struct packed {logic [W-1:0] d; logic tmo; logic [31:0] lat;} res_t;
    typedef struct packed {logic [31:0] dly; logic [W-1:0] v; logic stray;} mx_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    maxnet_job_ctrl_if #(.N_IN(N), .WIDTH(W)) bus();
    maxnet_job_ctrl #(.N_IN(N), .WIDTH(W), .START_CYCLES(SC), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    wr_t  wr_q[$];
    res_t res_q[$];
    mx_t  mx_q[$];

    logic [2*W+AW+4:0] regs;
    assign regs = {bus.mx_wr_en, bus.mx_wr_addr, bus.mx_wr_data, bus.mx_start,
                   bus.res_valid, bus.res_data, bus.res_timeout, bus.busy};

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Maxnet responder: done on WAIT cycle dly (0 = never), optional stray done during START
    bit ps = 1'b0, act = 1'b0;
    int k = 0;
    mx_t cur = '0;
    initial begin
        bus.mx_done = 1'b0;
        bus.mx_maxnumber = '0;
        forever begin
            @(posedge clk); #1;
            if (!rst) begin
                ps = 1'b0; act = 1'b0; bus.mx_done = 1'b0;
                continue;
            end
            bus.mx_done = 1'b0;
            bus.mx_maxnumber = $urandom;
            if (bus.mx_start && !ps) begin
                if (mx_q.size() > 0) begin
                    cur = mx_q.pop_front(); act = 1'b1; k = 0; bus.mx_done = cur.stray;
                end
            end else if (!bus.mx_start && ps && act) k = 1;
            else if (act && k > 0) k++;
            if (act && k > 0 && k == int'(cur.dly)) begin
                bus.mx_done = 1'b1; bus.mx_maxnumber = cur.v; act = 1'b0;
            end
            ps = bus.mx_start;
        end
    end

    bit sp = 1'b0, rvp = 1'b0, lwf = 1'b0, in_wait = 1'b0;
    int slen = 0, since = 0;
    initial begin
        wr_t we;
        res_t re;
        forever begin
            @(negedge clk);
            if (!rst) begin
                sp = 0; rvp = 0; lwf = 0; in_wait = 0; slen = 0; since = 0;
                continue;
            end
            if (bus.mx_wr_en) begin
                chk("write_expected", wr_q.size() > 0, 1);
                if (wr_q.size() > 0) begin
                    we = wr_q.pop_front();
                    chk("wr_addr", bus.mx_wr_addr, we.a);
                    chk("wr_data", bus.mx_wr_data, we.d);
                end
            end
            if (bus.mx_start) begin
                if (!sp) begin
                    chk("start_after_last_write", lwf, 1);
                    chk("writes_before_start", wr_q.size(), 0);
                end
                slen++;
            end else if (sp) begin
                chk("start_len", slen, SC);
                slen = 0; in_wait = 1; since = 0;
            end else if (in_wait) since++;
            if (bus.res_valid && !rvp) begin
                chk("result_expected", res_q.size() > 0, 1);
                if (res_q.size() > 0) begin
                    re = res_q.pop_front();
                    chk("res_data", bus.res_data, re.d);
                    chk("res_timeout", bus.res_timeout, re.tmo);
                    chk("wait_cycles", since, re.lat);
                end
                in_wait = 0;
            end
            sp = bus.mx_start;
            rvp = bus.res_valid;
            lwf = bus.mx_wr_en && bus.mx_wr_addr == AW'(N - 1);
        end
    end

    task automatic load(input logic [N-1:0][W-1:0] v, input logic [N-1:0][3:0] g);
        for (int i = 0; i < N; i++) begin
            bus.in_valid = 1'b0;
            repeat (int'(g[i])) begin @(posedge clk); #1; end
            bus.in_valid = 1'b1;
            bus.in_data = v[i];
            chk("in_ready_load", bus.in_ready, 1);
            chk("busy_load", bus.busy, i > 0);
            wr_q.push_back('{a: AW'(i), d: v[i]});
            @(posedge clk); #1;
        end
    endtask

    task automatic run_job(input logic [N-1:0][W-1:0] v, input logic [N-1:0][3:0] g,
                           input int d, input bit stray, input int bp, input bit hold,
                           input logic [W-1:0] nxt);
        logic [W-1:0] mx;
        bit ok;
        int n;
        mx = v[0];
        for (int i = 1; i < N; i++) if (v[i] > mx) mx = v[i];
        ok = d >= 1 && d <= TO;
        mx_q.push_back('{dly: d, v: mx, stray: stray});
        res_q.push_back('{d: ok ? mx : '0, tmo: !ok, lat: ok ? d : TO});
        load(v, g);
        bus.in_valid = hold;
        bus.in_data = nxt;
        n = 0;
        while (!bus.res_valid && n < 200) begin
            chk("in_ready_busy", bus.in_ready, 0);
            chk("busy_run", bus.busy, 1);
            @(posedge clk); #1;
            n++;
        end
        chk("res_valid_seen", bus.res_valid, 1);
        repeat (bp) begin
            chk("bp_in_ready", bus.in_ready, 0);
            chk("bp_res_valid", bus.res_valid, 1);
            chk("bp_res_data", bus.res_data, ok ? mx : '0);
            chk("bp_res_timeout", bus.res_timeout, !ok);
            @(posedge clk); #1;
        end
        bus.res_ready = 1'b1;
        @(posedge clk); #1;
        bus.res_ready = 1'b0;
        chk("res_valid_clr", bus.res_valid, 0);
        chk("res_timeout_clr", bus.res_timeout, 0);
        chk("res_data_retained", bus.res_data, ok ? mx : '0);
        chk("busy_clr", bus.busy, 0);
        chk("in_ready_after", bus.in_ready, 1);
    endtask

    task automatic reset_mid_job(input logic [N-1:0][W-1:0] v);
        mx_q.push_back('{dly: 0, v: '0, stray: 1'b0});
        load(v, '0);
        bus.in_valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        #3 rst = 1'b0;
        #1;
        chk("midjob_reset_regs", regs, 0);
        chk("midjob_reset_in_ready", bus.in_ready, 1);
        wr_q.delete(); res_q.delete(); mx_q.delete();
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        @(posedge clk); #1;
    endtask

    initial begin
        logic [N-1:0][W-1:0] v, vn;
        logic [N-1:0][3:0] g;
        bit carry, hold;
        logic [W-1:0] cv;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        bus.res_ready = 1'b0;
        #2;
        chk("reset_regs", regs, 0);
        chk("reset_in_ready", bus.in_ready, 1);
        #10 rst = 1'b1;
        @(posedge clk); #1;
        g = '0;
        v = {32'h40, 32'h03, 32'h7F, 32'h10};
        run_job(v, g, 20, 1'b0, 0, 1'b0, '0);
        v = {32'h55, 32'h12, 32'hA0, 32'h33};
        g = {4'd1, 4'd0, 4'd2, 4'd0};
        run_job(v, g, 4, 1'b1, 0, 1'b0, '0);
        g = '0;
        for (int i = 0; i < N; i++) v[i] = $urandom;
        run_job(v, g, 0, 1'b0, 1, 1'b0, '0);
        for (int i = 0; i < N; i++) v[i] = $urandom;
        run_job(v, g, 7, 1'b0, 0, 1'b0, '0);
        for (int i = 0; i < N; i++) begin v[i] = $urandom; vn[i] = $urandom; end
        run_job(v, g, 3, 1'b0, 5, 1'b1, vn[0]);
        run_job(vn, g, 2, 1'b0, 0, 1'b0, '0);
        for (int i = 0; i < N; i++) v[i] = $urandom;
        run_job(v, g, TO, 1'b0, 0, 1'b0, '0);
        for (int i = 0; i < N; i++) v[i] = $urandom;
        reset_mid_job(v);
        for (int i = 0; i < N; i++) v[i] = $urandom;
        run_job(v, g, 5, 1'b0, 0, 1'b0, '0);
        carry = 1'b0;
        cv = '0;
        for (int j = 0; j < 10; j++) begin
            for (int i = 0; i < N; i++) begin
                v[i] = $urandom;
                g[i] = 4'($urandom_range(0, 2));
            end
            if (carry) begin v[0] = cv; g[0] = '0; end
            hold = (j < 9) && ($urandom_range(0, 1) == 1);
            cv = $urandom;
            run_job(v, g, $urandom_range(0, TO + 3), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 3), hold, cv);
            carry = hold;
        end
        repeat (3) begin @(posedge clk); #1; end
        chk("queues_drained", wr_q.size() + res_q.size() + mx_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/maxnet_job_ctrl.md
# maxnet_job_ctrl

Synthesizable initiator for the Maxnet top module. It takes a stream of candidate values from a host and writes them into the Maxnet input bank. It then pulses `start`, waits for `done` under a timeout guard, and returns the captured maximum to the host through a valid/ready result port. It sits between the system host/DMA and the Maxnet core, and replaces the bench-only start/wait sequencing with a reusable hardware driver.

## Interface
- `N_IN`, 4: candidates per job; must be at least 2.
- `WIDTH`, 32: data width of candidates and result.
- `START_CYCLES`, 2: number of cycles `mx_start` is held high; must be at least 1.
- `TIMEOUT`, 1023: maximum number of WAIT cycles before the job is aborted; must be at least 1.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `in_valid` in 1: candidate valid from host.
- `in_ready` out 1: block accepts a candidate.
- `in_data` in WIDTH: candidate value.
- `mx_wr_en` out 1: Maxnet input-bank write strobe.
- `mx_wr_addr` out clog2(N_IN): write index.
- `mx_wr_data` out WIDTH: write data.
- `mx_start` out 1: Maxnet start.
- `mx_done` in 1: Maxnet completion, level or pulse.
- `mx_maxnumber` in WIDTH: Maxnet result, valid while `mx_done` is 1.
- `res_valid` out 1: result available.
- `res_ready` in 1: host accepts result.
- `res_data` out WIDTH: captured maximum, or 0 on timeout.
- `res_timeout` out 1: job aborted by the timeout guard; qualified by `res_valid`.
- `busy` out 1: a job is in progress.

## Operation
- FSM states: LOAD, START, WAIT, RESP. All outputs are registered except `in_ready`.
- Reset: state = LOAD, load count = 0. Every registered output is 0, including `mx_wr_en`, `mx_wr_addr`, `mx_wr_data`, `mx_start`, `res_valid`, `res_data`, `res_timeout` and `busy`. Reset asserted mid-job aborts the job immediately. Partial loads are discarded, and `mx_start` drops asynchronously.
- LOAD:
  - `in_ready` = 1.
  - Each `in_valid & in_ready` handshake writes the value on the next cycle: `mx_wr_en` = 1 for exactly one cycle, `mx_wr_addr` = load count, `mx_wr_data` = `in_data`. Then the count increments.
  - `in_valid` gaps are allowed, and the count holds through them.
  - `busy` = 1 once count > 0.
  - The handshake that brings the count to N_IN moves the FSM to START and resets the count to 0.
- START:
  - `in_ready` = 0.
  - `mx_start` = 1 for exactly START_CYCLES cycles.
  - `mx_done` is ignored in this state.
  - Then the FSM moves to WAIT and the timeout counter clears.
- WAIT:
  - The timeout counter increments every cycle.
  - If `mx_done` = 1, capture `mx_maxnumber` into `res_data`, set `res_timeout` = 0, `res_valid` = 1, and go to RESP.
  - Else, if the counter reaches TIMEOUT, set `res_data` = 0, `res_timeout` = 1, `res_valid` = 1, and go to RESP.
  - If `mx_done` and the timeout occur in the same cycle, `mx_done` wins.
- RESP:
  - `res_valid`, `res_data` and `res_timeout` hold stable until `res_ready` = 1.
  - On handshake: the FSM returns to LOAD, and on the next cycle `res_valid` = 0, `res_timeout` = 0 and `busy` = 0.
  - `res_data` retains its last value.
  - `in_ready` = 0 throughout RESP, so a new job cannot overlap a pending result.
- Width rules:
  - The load count is clog2(N_IN) bits plus headroom and never wraps past N_IN.
  - The timeout counter is clog2(TIMEOUT+1) bits and saturates.
- `busy` = 1 from the first accepted candidate until the cycle after the result handshake.

## Timing
- Let the final candidate handshake occur at edge t. Then:
  - `mx_wr_en` for the last index is high in cycle t+1, and the FSM is in START at t+1.
  - `mx_start` is high during cycles t+2 through t+1+START_CYCLES.
  - WAIT begins at cycle t+2+START_CYCLES.
- `mx_done` sampled high at WAIT edge w gives `res_valid` = 1 from cycle w+1.
- The timeout fires when exactly TIMEOUT WAIT cycles have elapsed without `mx_done`.
- Back-to-back jobs: the first candidate of the next job may be accepted in the cycle after the result handshake.
- Sustained load throughput is one candidate per cycle.
- Minimum job latency, from first candidate to `res_valid`, is N_IN + START_CYCLES + 2 cycles, assuming `mx_done` arrives on the first WAIT cycle.

## Test plan
- Nominal job: load 0x10, 0x7F, 0x03, 0x40 on consecutive cycles. The Maxnet model asserts `mx_done` with 0x7F 20 cycles after `mx_start` falls. Required: writes to addresses 0..3 carry those values in order, `mx_start` is high for exactly 2 cycles, `res_data` = 0x7F, and `res_timeout` = 0.
- Gapped input: `in_valid` toggles 1,0,0,1,1,0,1. Required: exactly 4 writes, addresses 0..3, no duplicated or dropped value, and no `mx_start` before the fourth write.
- Timeout: TIMEOUT = 15 and the model never asserts `mx_done`. Required: `res_valid` rises after exactly 15 WAIT cycles, with `res_data` = 0 and `res_timeout` = 1. Release `res_ready` and check that a second job then completes normally.
- Result backpressure: hold `res_ready` low for 5 cycles while `in_valid` is held high. Required: `res_valid` and `res_data` are stable, `in_ready` = 0, and the first new candidate is accepted in the cycle after the handshake.
- Reset mid-job: assert `rst` low during WAIT, asynchronously between clock edges. Required: all outputs go to 0 immediately. After release, `in_ready` = 1, the count restarts at address 0, and a fresh job returns the correct maximum.
- Done/timeout collision: TIMEOUT = 8 with `mx_done` on WAIT cycle 8. Required: `res_timeout` = 0 and `res_data` = `mx_maxnumber`.
